demux_1_to_2_reg: RTL and testbench
===================================

// Module: demux_1_to_2_reg
//
// PURPOSE
// Registered 1-to-2 demultiplexer for a valid/ready stream. Each accepted word
// goes to output 0 or output 1, chosen by a select bit that travels with the word.
// It is the counterpart of the 2-to-1 selection path: it splits one source into
// two sinks. Each output has its own one-entry holding register, so a stalled
// sink blocks only words addressed to it.
//
// PARAMETERS
// W      8   data width in bits
// CNT_W  8   width of each per-output transfer counter
//
// PORTS
// clk         in   1      clock; all state changes on rising edge
// rst         in   1      synchronous reset, active-high
// in_data     in   W      input word
// in_sel      in   1      destination of in_data: 0 -> out0, 1 -> out1
// in_valid    in   1      in_data/in_sel valid this cycle
// in_ready    out  1      block accepts the input word this cycle
// out0_data   out  W      output 0 word (registered)
// out0_valid  out  1      output 0 holds a word
// out0_ready  in   1      sink 0 takes the word this cycle
// out1_data   out  W      output 1 word (registered)
// out1_valid  out  1      output 1 holds a word
// out1_ready  in   1      sink 1 takes the word this cycle
// cnt0        out  CNT_W  number of words delivered on output 0 (wraps)
// cnt1        out  CNT_W  number of words delivered on output 1 (wraps)
//
// BEHAVIOUR
// - One clock, clk. rst is synchronous and active-high.
// - Reset: outX_valid=0, outX_data=0, cntX=0; in_ready=0 while rst is high.
// - Slot FSM per output X, two states:
//     EMPTY: outX_valid=0
//     FULL:  outX_valid=1
// - Input handshake:
//     accept = in_valid & in_ready
//     in_ready = !rst & (!outX_valid | outX_ready), where X = in_sel
//     in_ready depends combinationally on in_sel and the selected outX_ready.
// - in_sel is don't-care when in_valid=0.
// - Latency: a word accepted at edge N shows on outX_data/outX_valid after edge N.
//   This is 1 cycle with no bubble.
// - Output handshake: a transfer on X occurs when outX_valid & outX_ready at an edge.
// - Slot transitions for X:
//     EMPTY -> FULL   on accept with in_sel=X
//     FULL  -> EMPTY  on transfer without accept to X
//     FULL  -> FULL   on transfer plus accept to X in the same edge; data replaced,
//                     no bubble
//     FULL with outX_ready=0: outX_data and outX_valid stay stable; accept to X
//                     is impossible (in_ready=0)
// - The two outputs are independent:
//     a stall on X never blocks words addressed to the other output;
//     both outputs may transfer in the same cycle;
//     at most one input word is accepted per cycle.
// - Data is never dropped, duplicated or reordered per output.
// - outX_data is unchanged while outX_valid=0. Its last value is retained; there is
//   no zeroing after a transfer.
// - Counters: cntX increments by 1 on each transfer on X. It wraps modulo 2^CNT_W
//   (2^CNT_W-1 -> 0) with no saturation flag.
// - Reset mid-operation: held words are discarded, both slots go EMPTY and the
//   counters clear. An input offered while rst=1 is not accepted.
// - The first cycle after rst falls behaves like any idle cycle; in_ready=1 there.
//
// TESTING
// 1. Hold rst=1 for 2 cycles with in_valid=1 -> no accept; all valids 0; cnt0=cnt1=0;
//    in_ready=0.
// 2. With outX_ready=1, send A5 (sel0), 3C (sel1), FF (sel0), one per cycle
//    -> out0 shows A5 then FF, out1 shows 3C, each 1 cycle after accept;
//    cnt0=2, cnt1=1.
// 3. Hold out0_ready=0, send 11 (sel0) then 22 (sel0) and 33 (sel1)
//    -> 11 is held stable; in_ready=0 for 22; 33 is accepted and delivered on out1;
//    releasing out0_ready delivers 11 then 22.
// 4. Keep out0 FULL with out0_ready=1 and in_valid=1, sel0 every cycle for 10 cycles
//    -> in_ready stays 1, one word per cycle with no bubbles, cnt0 advances by 10.
// 5. With CNT_W=8, deliver 257 words to out1 -> cnt1 goes 255 -> 0 -> 1;
//    cnt0 stays unchanged.
// 6. Fill both slots with out ready=0, then pulse rst for 1 cycle -> both valids 0
//    and counters 0 after the edge; a new word sent next cycle is accepted.

Source files
------------

// File: rtl/demux_1_to_2_reg.sv
// demux_1_to_2_reg
// Registered 1-to-2 demultiplexer for a valid/ready stream. Each accepted word
// is steered to output 0 or output 1 by in_sel, which travels with the word.
// Each output has its own one-entry holding slot, so a stalled sink only blocks
// words addressed to it.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_data/in_sel/in_valid  input word, its destination, and its valid flag
//   in_ready                 input word is accepted this cycle
//   outX_data/outX_valid     registered output word and its valid flag (X=0,1)
//   outX_ready               sink X takes the word this cycle
//   cnt0, cnt1               words delivered per output, wrapping modulo 2^CNT_W
module demux_1_to_2_reg #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [W-1:0]     out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e            st_q   [2];
  slot_e            st_d   [2];
  logic [W-1:0]     data_q [2];
  logic [W-1:0]     data_d [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];

  logic [1:0] out_ready;
  logic [1:0] acc;
  logic [1:0] xfer;

  assign out_ready = {out1_ready, out0_ready};

  always_comb begin
    // The addressed slot can take a word if it is empty or is being drained
    // this same edge; the other slot's state is irrelevant.
    in_ready = !rst && ((st_q[in_sel] == SLOT_EMPTY) || out_ready[in_sel]);
    acc  = '0;
    xfer = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];

      xfer[i] = (st_q[i] == SLOT_FULL) && out_ready[i];
      acc[i]  = in_valid && in_ready && (in_sel == i[0]);

      if (xfer[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      // Accept wins over drain: a simultaneous transfer and accept keeps the
      // slot full with the new word, giving one word per cycle with no bubble.
      if (acc[i]) begin
        st_d[i]   = SLOT_FULL;
        data_d[i] = in_data;
      end else if (xfer[i]) begin
        st_d[i] = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]   <= SLOT_EMPTY;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign out0_valid = (st_q[0] == SLOT_FULL);
  assign out1_valid = (st_q[1] == SLOT_FULL);
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux_1_to_2_reg.sv
module tb_demux_1_to_2_reg;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [W-1:0]     in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [W-1:0]     out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  demux_1_to_2_reg #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: a word is delivered whenever valid & ready is seen mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out0_valid && out0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0_unexpected got %0h expected none", out0_data);
        end else begin
          logic [W-1:0] e0;
          e0 = q0.pop_front();
          if (out0_data !== e0) begin
            errors++;
            $display("FAIL out0_data got %0h expected %0h", out0_data, e0);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1_unexpected got %0h expected none", out1_data);
        end else begin
          logic [W-1:0] e1;
          e1 = q1.pop_front();
          if (out1_data !== e1) begin
            errors++;
            $display("FAIL out1_data got %0h expected %0h", out1_data, e1);
          end
        end
      end
    end
  end

  // Drive one word for one cycle; exp_rdy is the hand-derived acceptance.
  task automatic send(input logic [W-1:0] d, input logic s, input logic exp_rdy);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a word offered.
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h77;
    in_sel     = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_valid0", {31'd0, out0_valid}, 32'd0);
      chk("rst_valid1", {31'd0, out1_valid}, 32'd0);
      chk("rst_cnt0", {24'd0, cnt0}, 32'd0);
      chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
      @(posedge clk);
    end
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic steering, 1-cycle latency.
    send(8'hA5, 1'b0, 1'b1);
    chk("lat_valid0", {31'd0, out0_valid}, 32'd1);
    chk("lat_data0", {24'd0, out0_data}, 32'h A5);
    send(8'h3C, 1'b1, 1'b1);
    chk("lat_data1", {24'd0, out1_data}, 32'h3C);
    send(8'hFF, 1'b0, 1'b1);
    idle(2);
    chk("t2_cnt0", {24'd0, cnt0}, 32'd2);
    chk("t2_cnt1", {24'd0, cnt1}, 32'd1);
    chk("t2_hold_data0", {24'd0, out0_data}, 32'hFF);

    // Stall on out0 must not block out1.
    out0_ready = 1'b0;
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b0);
    chk("t3_stable_data0", {24'd0, out0_data}, 32'h11);
    chk("t3_stable_valid0", {31'd0, out0_valid}, 32'd1);
    send(8'h33, 1'b1, 1'b1);
    chk("t3_data1", {24'd0, out1_data}, 32'h33);
    chk("t3_stable_data0b", {24'd0, out0_data}, 32'h11);
    out0_ready = 1'b1;
    send(8'h22, 1'b0, 1'b1);
    chk("t3_replace_data0", {24'd0, out0_data}, 32'h22);
    idle(2);
    chk("t3_cnt0", {24'd0, cnt0}, 32'd4);
    chk("t3_cnt1", {24'd0, cnt1}, 32'd2);

    // Back-to-back on out0: no bubbles.
    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] w;
      w = 8'h40 + 8'(k);
      send(w, 1'b0, 1'b1);
      chk("t4_valid0", {31'd0, out0_valid}, 32'd1);
      chk("t4_data0", {24'd0, out0_data}, {24'd0, w});
    end
    idle(2);
    chk("t4_cnt0", {24'd0, cnt0}, 32'd14);

    // 257 words to out1: cnt1 starts at 2 and wraps through 255 -> 0 -> 1.
    for (int k = 1; k <= 257; k++) begin
      send(8'(k), 1'b1, 1'b1);
      if (k == 254) chk("t5_cnt1_255", {24'd0, cnt1}, 32'd255);
      if (k == 255) chk("t5_cnt1_0", {24'd0, cnt1}, 32'd0);
      if (k == 256) chk("t5_cnt1_1", {24'd0, cnt1}, 32'd1);
    end
    idle(2);
    chk("t5_cnt1_final", {24'd0, cnt1}, 32'd3);
    chk("t5_cnt0", {24'd0, cnt0}, 32'd14);

    // Fill both slots, then reset mid-operation.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'h5A, 1'b0, 1'b1);
    send(8'h6B, 1'b1, 1'b1);
    chk("t6_full0", {31'd0, out0_valid}, 32'd1);
    chk("t6_full1", {31'd0, out1_valid}, 32'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_sel   = 1'b0;
    @(negedge clk);
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    chk("t6_valid0", {31'd0, out0_valid}, 32'd0);
    chk("t6_valid1", {31'd0, out1_valid}, 32'd0);
    chk("t6_data0", {24'd0, out0_data}, 32'd0);
    chk("t6_cnt0", {24'd0, cnt0}, 32'd0);
    chk("t6_cnt1", {24'd0, cnt1}, 32'd0);
    out0_ready = 1'b1;
    send(8'hC3, 1'b0, 1'b1);
    chk("t6_new_data0", {24'd0, out0_data}, 32'hC3);
    idle(2);
    chk("t6_cnt0_after", {24'd0, cnt0}, 32'd1);
    chk("t6_cnt1_after", {24'd0, cnt1}, 32'd0);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
